mdl_dmaseq: RTL and testbench

MDL_DMASEQ -- requirements
Module: mdl_dmaseq

---
 rtl/mdl_dmaseq_pkg.sv | 31 +++
 rtl/mdl_dmaseq_wdt.sv | 37 +++
 rtl/mdl_dmaseq.sv | 171 +++++++++++++++++
 tb/tb_mdl_dmaseq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdl_dmaseq_pkg.sv
// Shared definitions for the DMA sequencer.
// Holds the sequencer state encoding, the DTACK watchdog limit and the
// maximum transfer length. Also provides the helper that maps the 9-bit
// length field onto a word count, where a zero field means 512 words.
package mdl_dmaseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_REQ  = 3'd2,
        ST_OWN  = 3'd3,
        ST_CYC  = 3'd4,
        ST_ADV  = 3'd5,
        ST_MSK  = 3'd6,
        ST_REL  = 3'd7
    } dma_state_t;

    localparam int         WDT_W     = 8;
    localparam logic [7:0] WDT_LIMIT = 8'd255;
    localparam int         MAX_LEN   = 512;
    localparam int         CNT_W     = 10;

    // A zero length field stands for the full 512-word transfer.
    function automatic logic [CNT_W-1:0] decode_len(input logic [8:0] len);
        if (len == 9'd0)
            return CNT_W'(MAX_LEN);
        else
            return {1'b0, len};
    endfunction

endpackage

// File: rtl/mdl_dmaseq_wdt.sv
// DTACK watchdog for the DMA sequencer.
// Counts clock-enabled cycles while a bus cycle is running and flags the
// enable on which the limit is reached without a data acknowledge.
// Ports:
//   i_MCLK, i_RST_n : master clock, asynchronous active-low reset
//   en              : 4 MHz clock enable (active high)
//   run             : high while the sequencer is in its bus-cycle state
//   dtack_n         : 68000 data acknowledge (active low)
//   expire          : high on the enable that completes the timeout
module mdl_dmawdt
    import mdl_dmaseq_pkg::*;
(
    input  logic i_MCLK,
    input  logic i_RST_n,
    input  logic en,
    input  logic run,
    input  logic dtack_n,
    output logic expire
);

    logic [WDT_W-1:0] wdt_cnt;

    // The count restarts for every bus cycle because it is held at zero
    // whenever the sequencer is outside the bus-cycle state.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n)
            wdt_cnt <= '0;
        else if (!run)
            wdt_cnt <= '0;
        else if (en && (wdt_cnt != WDT_LIMIT))
            wdt_cnt <= wdt_cnt + 8'd1;
    end

    // wdt_cnt holds the enables already spent, so this enable is the last one.
    assign expire = run && en && dtack_n && (wdt_cnt == (WDT_LIMIT - 8'd1));

endmodule

// File: rtl/mdl_dmaseq.sv
// DMA sequencer for the bubble-memory transfer path.
// Requests the 68000 bus, runs one bus cycle per word (or, in error-map
// mode, streams mask-address increments), then releases the bus.
// Ports:
//   i_MCLK, i_RST_n          : master clock, asynchronous active-low reset
//   i_CLK4M_PCEN_n           : active-low 4 MHz clock enable
//   i_ROT8                   : one-hot slot rotator
//   i_DMA_START              : transfer request level
//   i_DMA_MODE, i_XFER_LEN   : phase select and word count (0 = 512)
//   i_BG_n, i_BGACK_n, i_DTACK_n : 68000 bus grant / foreign BGACK / DTACK
//   o_BR_n, o_BGACK_n, o_AS_n    : 68000 bus request / BGACK / address strobe
//   o_ADDR_RST, o_BDRWADDR_INC, o_MSKADDR_INC : address counter controls
//   o_BUSY, o_DONE, o_BERR   : status, completion pulse, timeout pulse
module mdl_dmaseq
    import mdl_dmaseq_pkg::*;
(
    input  logic       i_MCLK,
    input  logic       i_RST_n,
    input  logic       i_CLK4M_PCEN_n,
    input  logic [7:0] i_ROT8,
    input  logic       i_DMA_START,
    input  logic       i_DMA_MODE,
    input  logic [8:0] i_XFER_LEN,
    input  logic       i_BG_n,
    input  logic       i_BGACK_n,
    input  logic       i_DTACK_n,
    output logic       o_BR_n,
    output logic       o_BGACK_n,
    output logic       o_AS_n,
    output logic       o_ADDR_RST,
    output logic       o_BDRWADDR_INC,
    output logic       o_MSKADDR_INC,
    output logic       o_BUSY,
    output logic       o_DONE,
    output logic       o_BERR
);

    dma_state_t       state;
    dma_state_t       state_nxt;
    logic             en;
    logic             mode_q;
    logic [CNT_W-1:0] word_cnt;
    logic             err_q;
    logic             msk_active;
    logic             wdt_expire;
    logic             last_word;
    logic             rot_ok;
    logic             slot0;
    logic             slot1;
    logic             slot7;

    assign en        = ~i_CLK4M_PCEN_n;
    assign last_word = (word_cnt <= CNT_W'(1));

    // A corrupted (non one-hot) rotator never triggers a slot event.
    assign rot_ok = $onehot(i_ROT8);
    assign slot0  = rot_ok && i_ROT8[0];
    assign slot1  = rot_ok && i_ROT8[1];
    assign slot7  = rot_ok && i_ROT8[7];

    mdl_dmawdt u_wdt (
        .i_MCLK  (i_MCLK),
        .i_RST_n (i_RST_n),
        .en      (en),
        .run     (state == ST_CYC),
        .dtack_n (i_DTACK_n),
        .expire  (wdt_expire)
    );

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n)
            state <= ST_IDLE;
        else if (en)
            state <= state_nxt;
    end

    // After each word ADV returns to OWN, which already waits for the next
    // slot 0 before starting the following bus cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_DMA_START) state_nxt = ST_CLR;
            ST_CLR:  state_nxt = ST_REQ;
            ST_REQ:  if (!i_BG_n && i_BGACK_n && i_DTACK_n) state_nxt = ST_OWN;
            ST_OWN:  if (slot0) state_nxt = mode_q ? ST_MSK : ST_CYC;
            ST_CYC: begin
                if (!i_DTACK_n)
                    state_nxt = ST_ADV;
                else if (wdt_expire)
                    state_nxt = ST_REL;
            end
            ST_ADV:  if (slot1) state_nxt = last_word ? ST_REL : ST_OWN;
            ST_MSK:  if (msk_active && slot7 && last_word) state_nxt = ST_REL;
            ST_REL:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Word counter, latched mode, timeout flag and mask-phase alignment.
    // The mask phase only starts counting periods at its first slot 0, so
    // each counted period spans slot 0 through slot 7.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            mode_q     <= 1'b0;
            word_cnt   <= '0;
            err_q      <= 1'b0;
            msk_active <= 1'b0;
        end else if (en) begin
            case (state)
                ST_CLR: begin
                    mode_q     <= i_DMA_MODE;
                    word_cnt   <= decode_len(i_XFER_LEN);
                    err_q      <= 1'b0;
                    msk_active <= 1'b0;
                end
                ST_CYC: begin
                    if (i_DTACK_n && wdt_expire)
                        err_q <= 1'b1;
                end
                ST_ADV: begin
                    if (slot1 && (word_cnt != '0))
                        word_cnt <= word_cnt - CNT_W'(1);
                end
                ST_MSK: begin
                    if (slot0)
                        msk_active <= 1'b1;
                    if (msk_active && slot7 && (word_cnt != '0))
                        word_cnt <= word_cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_BR_n         = 1'b1;
        o_BGACK_n      = 1'b1;
        o_AS_n         = 1'b1;
        o_ADDR_RST     = 1'b0;
        o_BDRWADDR_INC = 1'b0;
        o_MSKADDR_INC  = 1'b0;
        o_BUSY         = (state != ST_IDLE);
        o_DONE         = 1'b0;
        o_BERR         = 1'b0;
        case (state)
            ST_CLR: o_ADDR_RST = 1'b1;
            ST_REQ: o_BR_n = 1'b0;
            ST_OWN: o_BGACK_n = 1'b0;
            ST_CYC: begin
                o_BGACK_n = 1'b0;
                o_AS_n    = 1'b0;
            end
            ST_ADV: begin
                o_BGACK_n      = 1'b0;
                o_BDRWADDR_INC = 1'b1;
            end
            ST_MSK: begin
                o_BGACK_n     = 1'b0;
                o_MSKADDR_INC = msk_active || slot0;
            end
            ST_REL: begin
                o_DONE = ~err_q;
                o_BERR = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mdl_dmaseq.sv
// Self-checking bench for mdl_dmaseq.
// A bus responder grants the bus and acknowledges cycles after programmable
// delays; per-transfer event totals are compared against values derived
// from the transfer rules (word count, mode, delays, rotator period).
module tb_mdl_dmaseq;

    logic       i_MCLK = 1'b0;
    logic       i_RST_n = 1'b1;
    logic       i_CLK4M_PCEN_n = 1'b1;
    logic [7:0] i_ROT8 = 8'h01;
    logic       i_DMA_START = 1'b0;
    logic       i_DMA_MODE = 1'b0;
    logic [8:0] i_XFER_LEN = 9'd0;
    logic       i_BG_n = 1'b1;
    logic       i_BGACK_n = 1'b1;
    logic       i_DTACK_n = 1'b1;
    logic       o_BR_n, o_BGACK_n, o_AS_n;
    logic       o_ADDR_RST, o_BDRWADDR_INC, o_MSKADDR_INC;
    logic       o_BUSY, o_DONE, o_BERR;

    int total = 0;
    int bad = 0;

    int rotIdx, enPct;
    int gDelay, dDelay, hHold, asRun;
    int nAddrRst, nAsCyc, asEn, nRot1Inc, nMskInc, nDone, nBerr, nOverlap, brLow, bgackAtBerr;
    logic prevAs;

    always #5 i_MCLK = ~i_MCLK;

    mdl_dmaseq dut (
        .i_MCLK         (i_MCLK),
        .i_RST_n        (i_RST_n),
        .i_CLK4M_PCEN_n (i_CLK4M_PCEN_n),
        .i_ROT8         (i_ROT8),
        .i_DMA_START    (i_DMA_START),
        .i_DMA_MODE     (i_DMA_MODE),
        .i_XFER_LEN     (i_XFER_LEN),
        .i_BG_n         (i_BG_n),
        .i_BGACK_n      (i_BGACK_n),
        .i_DTACK_n      (i_DTACK_n),
        .o_BR_n         (o_BR_n),
        .o_BGACK_n      (o_BGACK_n),
        .o_AS_n         (o_AS_n),
        .o_ADDR_RST     (o_ADDR_RST),
        .o_BDRWADDR_INC (o_BDRWADDR_INC),
        .o_MSKADDR_INC  (o_MSKADDR_INC),
        .o_BUSY         (o_BUSY),
        .o_DONE         (o_DONE),
        .o_BERR         (o_BERR)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One master clock: drive inputs at the falling edge, look at the
    // outputs 1 ns later and account the upcoming rising edge if enabled.
    task automatic applyStimulus();
        @(negedge i_MCLK);
        i_CLK4M_PCEN_n = ($urandom_range(99) < enPct) ? 1'b0 : 1'b1;
        i_ROT8         = 8'(1 << rotIdx);
        i_BG_n         = !(o_BR_n == 1'b0 && brLow >= gDelay);
        i_BGACK_n      = !(o_BR_n == 1'b0 && brLow < hHold);
        i_DTACK_n      = !(o_AS_n == 1'b0 && asRun >= dDelay);
        #1;
        if (prevAs && !o_AS_n) nAsCyc++;
        prevAs = o_AS_n;
        if (!i_CLK4M_PCEN_n) begin
            if (o_ADDR_RST) nAddrRst++;
            if (!o_BR_n) brLow++;
            if (!o_AS_n) begin
                asEn++;
                asRun++;
            end else begin
                asRun = 0;
            end
            if (o_BDRWADDR_INC && i_ROT8[1]) nRot1Inc++;
            if (o_MSKADDR_INC) nMskInc++;
            if (o_BDRWADDR_INC && o_MSKADDR_INC) nOverlap++;
            if (o_DONE) nDone++;
            if (o_BERR) begin
                nBerr++;
                bgackAtBerr = o_BGACK_n;
            end
            rotIdx = (rotIdx + 1) % 8;
        end
    endtask

    task automatic runXfer(input string tag, input int mode, input int len,
                           input int g, input int d, input int h, input int budget);
        int cycles;
        bit seenEnd;
        nAddrRst = 0; nAsCyc = 0; asEn = 0; nRot1Inc = 0; nMskInc = 0;
        nDone = 0; nBerr = 0; nOverlap = 0; brLow = 0; bgackAtBerr = -1;
        asRun = 0; prevAs = 1'b1;
        gDelay = g; dDelay = d; hHold = h;
        i_DMA_MODE  = mode[0];
        i_XFER_LEN  = 9'(len);
        i_DMA_START = 1'b1;
        cycles  = 0;
        seenEnd = 0;
        while (cycles < budget && !(seenEnd && !o_BUSY)) begin
            applyStimulus();
            cycles++;
            if (o_BUSY) i_DMA_START = 1'b0;
            if (o_DONE || o_BERR) seenEnd = 1;
        end
        i_DMA_START = 1'b0;
        checkOutput({tag, ".finished"}, int'(seenEnd && !o_BUSY), 1);
    endtask

    task automatic checkRun(input string tag, input int mode, input int len,
                            input int g, input int d, input int h);
        int words;
        words = (len == 0) ? 512 : len;
        checkOutput({tag, ".addr_rst"}, nAddrRst, 1);
        checkOutput({tag, ".done"}, nDone, 1);
        checkOutput({tag, ".berr"}, nBerr, 0);
        checkOutput({tag, ".inc_overlap"}, nOverlap, 0);
        checkOutput({tag, ".br_enables"}, brLow, ((g > h) ? g : h) + 1);
        if (mode == 0) begin
            checkOutput({tag, ".as_cycles"}, nAsCyc, words);
            checkOutput({tag, ".as_enables"}, asEn, words * (d + 1));
            checkOutput({tag, ".rot1_inc"}, nRot1Inc, words);
            checkOutput({tag, ".msk_inc"}, nMskInc, 0);
        end else begin
            checkOutput({tag, ".as_cycles"}, nAsCyc, 0);
            checkOutput({tag, ".msk_inc"}, nMskInc, 8 * words);
            checkOutput({tag, ".rot1_inc"}, nRot1Inc, 0);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        logic [8:0] obs;
        obs = {o_BR_n, o_BGACK_n, o_AS_n, o_ADDR_RST, o_BDRWADDR_INC,
               o_MSKADDR_INC, o_BUSY, o_DONE, o_BERR};
        checkOutput(tag, int'(obs), int'(9'b111_000_000));
    endtask

    initial begin
        int m, l, g, d, h, cyc;
        rotIdx = $urandom_range(7);
        enPct  = 60;
        gDelay = 0; dDelay = 0; hHold = 0; asRun = 0; brLow = 0;
        prevAs = 1'b1;

        #2 i_RST_n = 1'b0;
        #1 checkResetOutputs("reset_state");
        #20;
        @(negedge i_MCLK);
        i_RST_n = 1'b1;
        repeat (3) applyStimulus();

        // Basic bubble-data transfer.
        runXfer("mode0_len3", 0, 3, 4, 2, 0, 4000);
        checkRun("mode0_len3", 0, 3, 4, 2, 0);

        // Error-map phase.
        runXfer("mode1_len4", 1, 4, 1, 0, 0, 4000);
        checkRun("mode1_len4", 1, 4, 1, 0, 0);

        // Foreign BGACK holds the sequencer in the request state.
        runXfer("bgack_hold", 0, 2, 0, 1, 6, 4000);
        checkRun("bgack_hold", 0, 2, 0, 1, 6);

        // Randomized transfers.
        for (int i = 0; i < 5; i++) begin
            m = $urandom_range(1);
            l = $urandom_range(6, 1);
            g = $urandom_range(5);
            d = $urandom_range(4);
            h = $urandom_range(3);
            enPct = $urandom_range(90, 40);
            runXfer($sformatf("rand%0d", i), m, l, g, d, h, 8000);
            checkRun($sformatf("rand%0d", i), m, l, g, d, h);
        end

        // DTACK never arrives: watchdog aborts the first word.
        enPct = 70;
        runXfer("timeout", 0, 2, 1, 100000, 0, 4000);
        checkOutput("timeout.berr", nBerr, 1);
        checkOutput("timeout.done", nDone, 0);
        checkOutput("timeout.as_enables", asEn, 255);
        checkOutput("timeout.as_cycles", nAsCyc, 1);
        checkOutput("timeout.bgack_at_berr", bgackAtBerr, 1);
        checkOutput("timeout.rot1_inc", nRot1Inc, 0);

        // Length 0 means 512 words.
        enPct = 85;
        runXfer("len0", 0, 0, 2, 0, 0, 40000);
        checkRun("len0", 0, 0, 2, 0, 0);

        // Reset in the middle of a bus cycle.
        enPct = 70;
        gDelay = 0; dDelay = 100000; hHold = 0; brLow = 0; asRun = 0;
        i_DMA_MODE = 1'b0;
        i_XFER_LEN = 9'd5;
        i_DMA_START = 1'b1;
        cyc = 0;
        while (cyc < 2000 && o_AS_n !== 1'b0) begin
            applyStimulus();
            if (o_BUSY) i_DMA_START = 1'b0;
            cyc++;
        end
        i_DMA_START = 1'b0;
        checkOutput("midcyc.reached_cyc", int'(o_AS_n === 1'b0), 1);
        repeat (3) applyStimulus();
        #2 i_RST_n = 1'b0;
        #1 checkResetOutputs("midcyc.reset_outputs");
        @(negedge i_MCLK);
        i_RST_n = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("midcyc.idle_after", int'(o_BUSY), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
